// File: rtl/shared_counter_ctrl_if.sv
// Bus between the shared interval counter controller and its requesters.
// The master side is the requester bank; the slave side is the controller.
interface shared_counter_ctrl_if #(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 8
);
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*CNT_W-1:0] len;
    logic [NUM_REQ-1:0]       grant;
    logic [NUM_REQ-1:0]       done;
    logic                     busy;
    logic [CNT_W-1:0]         count;

    modport master (
        output req,
        output len,
        input  grant,
        input  done,
        input  busy,
        input  count
    );

    modport slave (
        input  req,
        input  len,
        output grant,
        output done,
        output busy,
        output count
    );
endinterface

// File: rtl/shared_counter_ctrl.sv
// Round-robin owner of one shared up-counter: the winner gets len+1 counting
// cycles, then a one-cycle done pulse, unless it drops req first (abort).
module shared_counter_ctrl #(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 8
) (
    input logic                  clk,
    input logic                  reset,
    shared_counter_ctrl_if.slave bus
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        DONE
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   owner;
    logic [IDX_W-1:0]   winner;
    logic [IDX_W-1:0]   next_ptr;
    logic               found;
    logic [CNT_W-1:0]   target;
    logic [CNT_W-1:0]   count_q;
    logic [NUM_REQ-1:0] grant_q;
    logic [NUM_REQ-1:0] done_q;
    logic               busy_q;
    logic [CNT_W-1:0]   len_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_len
        assign len_arr[i] = bus.len[i*CNT_W +: CNT_W];
    end

    // First requester at or above rr_ptr, wrapping around, wins the counter.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && bus.req[(int'(rr_ptr) + k) % NUM_REQ]) begin
                found  = 1'b1;
                winner = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
            end
        end
    end

    assign next_ptr = (int'(owner) == NUM_REQ - 1) ? '0 : owner + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            rr_ptr  <= '0;
            owner   <= '0;
            target  <= '0;
            count_q <= '0;
            grant_q <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        grant_q <= NUM_REQ'(1) << winner;
                        owner   <= winner;
                        target  <= len_arr[winner];
                        count_q <= '0;
                        busy_q  <= 1'b1;
                        state   <= COUNT;
                    end
                end
                COUNT: begin
                    // A dropped request wins over reaching the target.
                    if (!bus.req[owner]) begin
                        grant_q <= '0;
                        count_q <= '0;
                        busy_q  <= 1'b0;
                        rr_ptr  <= next_ptr;
                        state   <= IDLE;
                    end else if (count_q == target) begin
                        done_q  <= grant_q;
                        grant_q <= '0;
                        count_q <= '0;
                        rr_ptr  <= next_ptr;
                        state   <= DONE;
                    end else begin
                        count_q <= count_q + 1'b1;
                    end
                end
                DONE: begin
                    done_q <= '0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    grant_q <= '0;
                    done_q  <= '0;
                    count_q <= '0;
                    busy_q  <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign bus.grant = grant_q;
    assign bus.done  = done_q;
    assign bus.busy  = busy_q;
    assign bus.count = count_q;

endmodule

// File: tb/tb_shared_counter_ctrl.sv
// Directed bench for shared_counter_ctrl: a per-interval reference model is
// compared every cycle, and literal expectations pin the key sequences.
module tb_shared_counter_ctrl;

    localparam int N = 4;
    localparam int W = 8;

    logic clk;
    logic reset;
    int   check_count = 0;
    int   fail_count  = 0;

    shared_counter_ctrl_if #(.NUM_REQ(N), .CNT_W(W)) bus_if ();

    shared_counter_ctrl #(.NUM_REQ(N), .CNT_W(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    // Reference model: phase 0 = no owner, 1 = interval running, 2 = completion cycle.
    int m_phase, m_owner, m_tgt, m_left, m_ptr;

    always @(posedge clk or negedge reset) begin
        int ph, ow, tg, lf, pt;
        if (!reset) begin
            m_phase <= 0;
            m_owner <= 0;
            m_tgt   <= 0;
            m_left  <= 0;
            m_ptr   <= 0;
        end else begin
            ph = m_phase; ow = m_owner; tg = m_tgt; lf = m_left; pt = m_ptr;
            if (ph == 2) begin
                ph = 0;
            end else if (ph == 1) begin
                if (!bus_if.req[ow]) begin
                    ph = 0;
                    pt = (ow + 1) % N;
                end else if (lf == 0) begin
                    ph = 2;
                    pt = (ow + 1) % N;
                end else begin
                    lf = lf - 1;
                end
            end else begin
                for (int k = 0; k < N; k++) begin
                    if (ph == 0 && bus_if.req[(pt + k) % N]) begin
                        ph = 1;
                        ow = (pt + k) % N;
                        tg = int'(bus_if.len[ow*W +: W]);
                        lf = tg;
                    end
                end
            end
            m_phase <= ph;
            m_owner <= ow;
            m_tgt   <= tg;
            m_left  <= lf;
            m_ptr   <= pt;
        end
    end

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        check_count++;
        if (act !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            check_val("model_grant", 32'(bus_if.grant),
                      (m_phase == 1) ? (32'd1 << m_owner) : 32'd0);
            check_val("model_done", 32'(bus_if.done),
                      (m_phase == 2) ? (32'd1 << m_owner) : 32'd0);
            check_val("model_busy", 32'(bus_if.busy), (m_phase != 0) ? 32'd1 : 32'd0);
            check_val("model_count", 32'(bus_if.count),
                      (m_phase == 1) ? 32'(m_tgt - m_left) : 32'd0);
            check_val("inv_grant_onehot0", 32'($onehot0(bus_if.grant)), 32'd1);
            check_val("inv_done_onehot0", 32'($onehot0(bus_if.done)), 32'd1);
            check_val("inv_done_vs_grant", 32'(bus_if.done & bus_if.grant), 32'd0);
            check_val("inv_idle_no_grant", 32'(!bus_if.busy && (bus_if.grant != '0)), 32'd0);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [N-1:0] r, input logic [N*W-1:0] l);
        bus_if.req = r;
        bus_if.len = l;
    endtask

    task automatic checkOutput(input string name, input logic [N-1:0] g, input logic [N-1:0] d,
                               input logic b, input int c);
        check_val({name, "_grant"}, 32'(bus_if.grant), 32'(g));
        check_val({name, "_done"},  32'(bus_if.done),  32'(d));
        check_val({name, "_busy"},  32'(bus_if.busy),  32'(b));
        check_val({name, "_count"}, 32'(bus_if.count), 32'(c));
    endtask

    initial begin
        reset = 1'b0;
        applyStimulus('0, '0);

        $display("[TB] test 1: reset and asynchronous abort");
        repeat (5) tick();
        reset = 1'b1;
        checkOutput("reset_state", 4'b0000, 4'b0000, 1'b0, 0);
        applyStimulus(4'b0001, {8'd0, 8'd0, 8'd0, 8'd10});
        repeat (6) tick();
        checkOutput("t1_count5", 4'b0001, 4'b0000, 1'b1, 5);
        #2 reset = 1'b0;
        #1 checkOutput("t1_async_reset", 4'b0000, 4'b0000, 1'b0, 0);
        tick();
        reset = 1'b1;
        applyStimulus('0, '0);
        checkOutput("t1_no_done", 4'b0000, 4'b0000, 1'b0, 0);
        tick();
        checkOutput("t1_still_idle", 4'b0000, 4'b0000, 1'b0, 0);

        $display("[TB] test 2: single interval len=3");
        applyStimulus(4'b0001, {8'd0, 8'd0, 8'd0, 8'd3});
        for (int k = 0; k <= 3; k++) begin
            tick();
            checkOutput("t2_count", 4'b0001, 4'b0000, 1'b1, k);
        end
        tick();
        checkOutput("t2_done", 4'b0000, 4'b0001, 1'b1, 0);
        applyStimulus('0, '0);
        tick();
        checkOutput("t2_idle", 4'b0000, 4'b0000, 1'b0, 0);

        $display("[TB] test 3: round-robin between requesters 0 and 2");
        reset = 1'b0;
        tick();
        reset = 1'b1;
        applyStimulus(4'b0101, {8'd0, 8'd2, 8'd0, 8'd2});
        for (int r = 0; r < 2; r++) begin
            logic [N-1:0] g;
            g = (r == 0) ? 4'b0001 : 4'b0100;
            for (int k = 0; k <= 2; k++) begin
                tick();
                checkOutput("t3_count", g, 4'b0000, 1'b1, k);
            end
            tick();
            checkOutput("t3_done", 4'b0000, g, 1'b1, 0);
            if (r == 1) applyStimulus(4'b0001, {8'd0, 8'd2, 8'd0, 8'd2});
            tick();
            checkOutput("t3_gap", 4'b0000, 4'b0000, 1'b0, 0);
        end
        tick();
        checkOutput("t3_regrant0", 4'b0001, 4'b0000, 1'b1, 0);
        applyStimulus('0, '0);
        tick();
        checkOutput("t3_abort", 4'b0000, 4'b0000, 1'b0, 0);

        $display("[TB] test 4: zero-length interval");
        applyStimulus(4'b0010, '0);
        tick();
        checkOutput("t4_count0", 4'b0010, 4'b0000, 1'b1, 0);
        tick();
        checkOutput("t4_done", 4'b0000, 4'b0010, 1'b1, 0);
        applyStimulus('0, '0);
        tick();
        checkOutput("t4_idle", 4'b0000, 4'b0000, 1'b0, 0);

        $display("[TB] test 5: abort and pointer advance");
        applyStimulus(4'b0010, {8'd0, 8'd0, 8'd10, 8'd0});
        for (int k = 0; k <= 4; k++) begin
            tick();
            checkOutput("t5_count", 4'b0010, 4'b0000, 1'b1, k);
        end
        applyStimulus(4'b0000, {8'd0, 8'd0, 8'd10, 8'd0});
        tick();
        checkOutput("t5_abort", 4'b0000, 4'b0000, 1'b0, 0);
        applyStimulus(4'b1010, {8'd1, 8'd0, 8'd7, 8'd0});
        tick();
        checkOutput("t5_grant3", 4'b1000, 4'b0000, 1'b1, 0);
        tick();
        checkOutput("t5_count1", 4'b1000, 4'b0000, 1'b1, 1);
        tick();
        checkOutput("t5_done", 4'b0000, 4'b1000, 1'b1, 0);
        applyStimulus('0, '0);
        tick();
        checkOutput("t5_idle", 4'b0000, 4'b0000, 1'b0, 0);

        $display("[TB] test 6: full-range interval len=255");
        applyStimulus(4'b1000, {8'd255, 8'd0, 8'd0, 8'd0});
        for (int k = 0; k <= 255; k++) begin
            tick();
            checkOutput("t6_count", 4'b1000, 4'b0000, 1'b1, k);
            if (k == 50) applyStimulus(4'b1000, {8'd5, 8'd0, 8'd0, 8'd0});
            if (k == 100) applyStimulus(4'b1001, {8'd5, 8'd0, 8'd0, 8'd0});
        end
        tick();
        checkOutput("t6_done", 4'b0000, 4'b1000, 1'b1, 0);
        applyStimulus(4'b0001, {8'd5, 8'd0, 8'd0, 8'd0});
        tick();
        checkOutput("t6_idle", 4'b0000, 4'b0000, 1'b0, 0);
        tick();
        checkOutput("t6_grant0", 4'b0001, 4'b0000, 1'b1, 0);
        applyStimulus('0, {8'd5, 8'd0, 8'd0, 8'd0});
        tick();
        checkOutput("t6_abort_prio", 4'b0000, 4'b0000, 1'b0, 0);
        tick();

        $display("[TB] End of test - %0d assertions evaluated, %0d failures", check_count, fail_count);
        $finish;
    end

endmodule
